// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared constants for the interrupt controller
package int_pkg;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_EDGE = 2'd1;
    localparam logic [1:0] REG_PEND = 2'd2;
    localparam logic [1:0] REG_INSV = 2'd3;

    // Cause reserved for the CPU software trap; CAUSE_BASE must keep clear of it.
    localparam int CAUSE_SW = 8;

endpackage

// File: rtl/prio_enc.sv
// rtl/prio_enc.sv - lowest-index-wins priority encoder
module prio_enc #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = |vec;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - multi-source interrupt controller with mask, edge/level capture and nesting
module int_ctrl
    import int_pkg::*;
#(
    parameter int N_SRC      = 8,
    parameter int NUM_W      = 32,
    parameter int CAUSE_BASE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic             int_req,
    output logic [NUM_W-1:0] int_num,
    input  logic             int_ack,
    input  logic             eoi
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] mask, edge_mode, pend, insv, src_q;
    logic [N_SRC-1:0] pend_n, insv_n, rise, w1c, ack_bit, eoi_bit, below, cand_vec;
    logic [IW-1:0]    cur_idx, cand_idx, insv_idx;
    logic             cand_vld, insv_vld, ack_take;
    logic             unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    prio_enc #(.W(N_SRC), .IW(IW)) u_insv_enc (.vec(insv),     .valid(insv_vld), .idx(insv_idx));
    prio_enc #(.W(N_SRC), .IW(IW)) u_cand_enc (.vec(cand_vec), .valid(cand_vld), .idx(cand_idx));

    always_comb begin
        ack_take = int_ack & int_req;
        ack_bit  = ack_take ? (N_SRC'(1) << cur_idx) : '0;
        eoi_bit  = (eoi && insv_vld) ? (N_SRC'(1) << insv_idx) : '0;
        w1c      = (cfg_we && cfg_addr == REG_PEND) ? cfg_wdata[N_SRC-1:0] : '0;
        rise     = src & ~src_q;
        // A new edge wins over a same-cycle ack or W1C on that bit.
        pend_n   = (edge_mode & (rise | (pend & ~(ack_bit | w1c)))) | (~edge_mode & src);
        // EOI retires the old lowest in-service bit before the ack adds the new one.
        insv_n   = (insv & ~eoi_bit) | ack_bit;
        below    = insv_vld ? ((N_SRC'(1) << insv_idx) - N_SRC'(1)) : '1;
        cand_vec = pend & mask & below;
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            REG_MASK: cfg_rdata = 32'(mask);
            REG_EDGE: cfg_rdata = 32'(edge_mode);
            REG_PEND: cfg_rdata = 32'(pend);
            REG_INSV: cfg_rdata = 32'(insv);
            default:  cfg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask      <= '0;
            edge_mode <= '0;
            pend      <= '0;
            insv      <= '0;
            src_q     <= '0;
            cur_idx   <= '0;
            int_req   <= 1'b0;
            int_num   <= '0;
        end else begin
            src_q <= src;
            pend  <= pend_n;
            insv  <= insv_n;
            if (cfg_we && cfg_addr == REG_MASK) mask      <= cfg_wdata[N_SRC-1:0];
            if (cfg_we && cfg_addr == REG_EDGE) edge_mode <= cfg_wdata[N_SRC-1:0];
            // The cycle after an ack the request is forced low so the CPU never sees a stale cause.
            if (ack_take) begin
                int_req <= 1'b0;
                int_num <= '0;
            end else begin
                int_req <= cand_vld;
                int_num <= cand_vld ? (NUM_W'(CAUSE_BASE) + NUM_W'(cand_idx)) : '0;
                cur_idx <= cand_idx;
            end
        end
    end

endmodule
